// File: rtl/top_pkg.sv
// Shared widths, defaults and data-pattern helpers for the
// command/response self-test block.
package top_pkg;

    localparam int CMD_W             = 16;
    localparam int DEF_NUM_CMDS      = 32;
    localparam int DEF_FIFO_DEPTH    = 16;
    localparam int DEF_PROC_INTERVAL = 4;

    function automatic logic [CMD_W-1:0] cmd_word(
        input logic [7:0] k
    );
        logic [7:0] lo;
        lo = k * 8'd3 + 8'd1;
        return {k, lo};
    endfunction

    function automatic logic [CMD_W-1:0] exp_resp(
        input logic [7:0] j
    );
        logic [7:0] lo;
        lo = j * 8'd3 + 8'd1;
        return {j, ~lo};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and
// wrap-bit pointers for full/empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;

    // Storage carries no reset; only pointers define occupancy.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            o_rd_data <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                o_rd_data <= r_mem[r_rptr[AW-1:0]];
                r_rptr    <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/top.sv
// Command generator, rate-limited processor and response checker
// wrapped around two FIFOs; reports pass/fail per run.
module top
    import top_pkg::*;
#(
    parameter int NUM_CMDS      = DEF_NUM_CMDS,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int PROC_INTERVAL = DEF_PROC_INTERVAL
) (
    input  logic clk,
    input  logic rst,
    input  logic start_test,
    output logic busy,
    output logic success
);

    logic             cmd_fifo_wr_en;
    logic [CMD_W-1:0] cmd_fifo_wr_data;
    logic             cmd_fifo_rd_en;
    logic [CMD_W-1:0] cmd_fifo_rd_data;
    logic             cmd_fifo_full;
    logic             cmd_fifo_empty;
    logic             resp_fifo_wr_en;
    logic [CMD_W-1:0] resp_fifo_wr_data;
    logic             resp_fifo_rd_en;
    logic [CMD_W-1:0] resp_fifo_rd_data;
    logic             resp_fifo_full;
    logic             resp_fifo_empty;

    logic        r_start_q;
    logic        r_busy;
    logic        r_success;
    logic        r_error;
    logic        r_resp_pend;
    logic        r_chk_pend;
    logic [8:0]  r_k;
    logic [8:0]  r_j;
    logic [15:0] r_ivl;
    logic        w_accept;
    logic        w_done;

    assign busy     = r_busy;
    assign success  = r_success;
    assign w_accept = start_test && !r_start_q && !r_busy;
    assign w_done   = r_busy && (r_j == 9'(NUM_CMDS));

    assign cmd_fifo_wr_en   = r_busy && (r_k < 9'(NUM_CMDS));
    assign cmd_fifo_wr_data = cmd_word(r_k[7:0]);

    // Holding off while a response write is pending guarantees that
    // write always finds room, even at an interval of one.
    assign cmd_fifo_rd_en = r_busy && (r_ivl == '0) &&
                            !cmd_fifo_empty && !resp_fifo_full &&
                            !r_resp_pend;

    assign resp_fifo_wr_en   = r_resp_pend;
    assign resp_fifo_wr_data = {cmd_fifo_rd_data[15:8],
                                ~cmd_fifo_rd_data[7:0]};
    assign resp_fifo_rd_en   = r_busy && !resp_fifo_empty;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) cmd_fifo_inst (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (cmd_fifo_wr_en),
        .i_wr_data (cmd_fifo_wr_data),
        .i_rd_en   (cmd_fifo_rd_en),
        .o_rd_data (cmd_fifo_rd_data),
        .o_full    (cmd_fifo_full),
        .o_empty   (cmd_fifo_empty)
    );

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) resp_fifo_inst (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (resp_fifo_wr_en),
        .i_wr_data (resp_fifo_wr_data),
        .i_rd_en   (resp_fifo_rd_en),
        .o_rd_data (resp_fifo_rd_data),
        .o_full    (resp_fifo_full),
        .o_empty   (resp_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_busy      <= 1'b0;
            r_success   <= 1'b0;
            r_error     <= 1'b0;
            r_resp_pend <= 1'b0;
            r_chk_pend  <= 1'b0;
            r_k         <= '0;
            r_j         <= '0;
            r_ivl       <= '0;
        end else begin
            r_start_q   <= start_test;
            r_resp_pend <= cmd_fifo_rd_en;
            r_chk_pend  <= resp_fifo_rd_en;
            if (cmd_fifo_rd_en) begin
                r_ivl <= 16'(PROC_INTERVAL - 1);
            end else if (r_ivl != '0) begin
                r_ivl <= r_ivl - 1'b1;
            end
            if (w_accept) begin
                r_busy    <= 1'b1;
                r_success <= 1'b0;
                r_error   <= 1'b0;
                r_k       <= '0;
                r_j       <= '0;
            end else begin
                if (cmd_fifo_wr_en && !cmd_fifo_full) begin
                    r_k <= r_k + 1'b1;
                end
                if (r_chk_pend) begin
                    if (resp_fifo_rd_data != exp_resp(r_j[7:0])) begin
                        r_error <= 1'b1;
                    end
                    r_j <= r_j + 1'b1;
                end
                if (w_done) begin
                    r_busy    <= 1'b0;
                    r_success <= !r_error;
                end
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for top: runs, restart, ignored start,
// mid-run reset and injected response corruption.
module tb_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_test = 1'b0;
    logic busy;
    logic success;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_cmd = 0;
    int mon_resp = 0;
    bit chk_resp = 1'b1;
    bit saw_full = 1'b0;

    top dut (
        .clk        (clk),
        .rst        (rst),
        .start_test (start_test),
        .busy       (busy),
        .success    (success)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cmd(input int k);
        return 16'(((k % 256) << 8) | ((3 * k + 1) % 256));
    endfunction

    function automatic logic [15:0] exp_rsp(input int k);
        return 16'(((k % 256) << 8) | (255 - ((3 * k + 1) % 256)));
    endfunction

    // Independent observation of the FIFO write streams.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.cmd_fifo_full) saw_full = 1'b1;
            if (dut.cmd_fifo_wr_en && !dut.cmd_fifo_full) begin
                check("cmd_seq", dut.cmd_fifo_wr_data, exp_cmd(mon_cmd));
                mon_cmd++;
            end
            if (dut.resp_fifo_wr_en && !dut.resp_fifo_full) begin
                if (chk_resp)
                    check("resp_seq", dut.resp_fifo_wr_data,
                          exp_rsp(mon_resp));
                mon_resp++;
            end
        end
    end

    task automatic clear_mon();
        mon_cmd  = 0;
        mon_resp = 0;
        saw_full = 1'b0;
    endtask

    task automatic start_run(input string tag);
        clear_mon();
        @(negedge clk);
        start_test = 1'b1;
        @(negedge clk);
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_succ_low"}, success, 0);
        @(negedge clk);
        @(negedge clk);
        start_test = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: busy=%0b", busy);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (10) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_succ", success, 0);
        check("rst_cmd_empty", dut.cmd_fifo_empty, 1);
        check("rst_resp_empty", dut.resp_fifo_empty, 1);
        rst = 1'b0;
        @(negedge clk);

        start_run("run1");
        wait_idle("run1", 4 * 32 + 10);
        check("run1_succ", success, 1);
        check("run1_ncmd", mon_cmd, 32);
        check("run1_nresp", mon_resp, 32);
        check("run1_full", saw_full, 1);

        start_run("run2");
        repeat (10) @(negedge clk);
        start_test = 1'b1;
        repeat (2) @(negedge clk);
        check("run2_still_busy", busy, 1);
        check("run2_succ_mid", success, 0);
        start_test = 1'b0;
        wait_idle("run2", 4 * 32 + 10);
        check("run2_succ", success, 1);
        check("run2_ncmd", mon_cmd, 32);
        check("run2_nresp", mon_resp, 32);
        repeat (10) @(negedge clk);
        check("run2_no_rerun", busy, 0);
        check("run2_nresp_hold", mon_resp, 32);

        start_run("run3");
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_succ", success, 0);
        check("mid_rst_cmd_empty", dut.cmd_fifo_empty, 1);
        check("mid_rst_resp_empty", dut.resp_fifo_empty, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        start_run("run4");
        wait_idle("run4", 4 * 32 + 10);
        check("run4_succ", success, 1);
        check("run4_nresp", mon_resp, 32);

        chk_resp = 1'b0;
        start_run("run5");
        begin
            int n = 0;
            while (!dut.resp_fifo_wr_en && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("run5_resp_seen", dut.resp_fifo_wr_en, 1);
        end
        force dut.resp_fifo_wr_data = 16'h00FF;
        @(posedge clk);
        #1;
        release dut.resp_fifo_wr_data;
        wait_idle("run5", 4 * 32 + 10);
        check("run5_succ_bad", success, 0);
        check("run5_nresp", mon_resp, 32);
        chk_resp = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter NUM_CMDS, default 32, is the number of commands issued per test run (1..255).
REQ-002 Parameter FIFO_DEPTH, default 16, is the depth of each internal FIFO (power of two).
REQ-003 Parameter PROC_INTERVAL, default 4, is the minimum number of cycles between processor command reads (>=1).
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start_test  input  1  level; a 0->1 transition requests a test run.
REQ-007 busy  output  1  high while a run is in progress.
REQ-008 success  output  1  result of the last completed run; 1 = all responses verified.

Function
REQ-009 Start is detected as start_test high while its registered copy is low; busy rises the cycle after detection.
REQ-010 A start detected while busy=1 is ignored.
REQ-011 On accepted start: success cleared to 0; command index, response index and error flag cleared.
REQ-012 Generator: while busy and index k<NUM_CMDS, assert cmd_fifo_wr_en with cmd_fifo_wr_data={k[7:0], (3*k+1) mod 256}, 16 bits; increment k only on accepted write.
REQ-013 A FIFO write is accepted iff wr_en && !full; a read is accepted iff rd_en && !empty; refused operations change nothing.
REQ-014 FIFO read data is registered: rd_data is valid the cycle after an accepted read and holds until the next accepted read.
REQ-015 Simultaneous accepted read and write leave the occupancy unchanged; pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
REQ-016 full = occupancy==FIFO_DEPTH; empty = occupancy==0; both combinational from the pointers.
REQ-017 Processor: at most one cmd_fifo_rd_en per PROC_INTERVAL cycles, only when cmd FIFO is not empty and response FIFO is not full.
REQ-018 The cycle after a processor read, resp_fifo_wr_en=1 with resp_fifo_wr_data={cmd[15:8], ~cmd[7:0]}.
REQ-019 Checker: asserts resp_fifo_rd_en whenever response FIFO is not empty and busy; the cycle after each accepted read, it compares data with {j[7:0], ~((3*j+1) mod 256)} for response index j, then increments j.
REQ-020 Any mismatch sets a sticky error flag for the run.
REQ-021 When j reaches NUM_CMDS: busy falls next cycle; success = !error in the same cycle; success holds until the next accepted start or reset.
REQ-022 The command FIFO fills under the default parameters, so the generator stalls; no command is lost or duplicated.
REQ-023 Internal signal names: cmd_fifo_wr_en, cmd_fifo_wr_data, cmd_fifo_rd_en, cmd_fifo_rd_data, cmd_fifo_full, cmd_fifo_empty, and resp_fifo_* equivalents, so they are probeable hierarchically.

Reset
REQ-024 With rst=1 at a clock edge: busy=0, success=0, both FIFOs empty, all indices, interval counter, error and start-edge register cleared.
REQ-025 Reset mid-run aborts the run; no outputs change until a new start after rst deasserts.

Structure
REQ-026 A shared package holds the command/response width (16), the expected-data function, and the default parameter values.
REQ-027 One sub-module, sync_fifo (parameters WIDTH, DEPTH), is instantiated twice as cmd_fifo_inst and resp_fifo_inst; generator, processor and checker stay in top.

Verification
REQ-028 Reset 10 cycles, start_test high 3 cycles -> busy=1 the cycle after the edge; busy falls within 4*32+10 cycles; success=1.
REQ-029 Default run -> cmd writes appear as 0x0001, 0x0104, 0x0207, ... 0x1F5E, in order; cmd_fifo_full asserts at least once; responses appear as 0x00FE, 0x01FB, ...
REQ-030 Second start after completion -> sequence restarts at 0x0001; success=0 during the run, then 1 at the end.
REQ-031 Start edge while busy -> ignored; the run count stays at 32 responses.
REQ-032 rst asserted mid-run -> next cycle busy=0, success=0, both empty flags=1; a subsequent start completes with success=1.
REQ-033 Forced corruption of one response bit via a hierarchical force -> run completes with busy=0 and success=0.
